// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light encodings, phase enum and BCD helpers for the phase timer
package traffic_pkg;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } phase_t;

  // Packs a 0..99 value as {tens, ones}.
  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] light_sel(input phase_t p);
    case (p)
      GREEN:   light_sel = LIGHT_GREEN;
      YELLOW:  light_sel = LIGHT_YELLOW;
      default: light_sel = LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// rtl/bcd_down_counter.sv - two-digit BCD down counter with synchronous load and zero flag
module bcd_down_counter #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= RESET_VAL[7:4];
      ones <= RESET_VAL[3:0];
    end else if (load) begin
      tens <= load_val[7:4];
      ones <= load_val[3:0];
    end else if (dec) begin
      if (ones != 4'd0) begin
        ones <= ones - 4'd1;
      end else if (tens != 4'd0) begin
        // Borrow from tens; 00 simply holds so digits never leave 0..9.
        ones <= 4'd9;
        tens <= tens - 4'd1;
      end
    end
  end

  assign zero = (tens == 4'd0) && (ones == 4'd0);

endmodule

// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - prescaled GREEN/YELLOW/RED phase timer with BCD countdown digits
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int CLK_DIV     = 100000000,
  parameter int GREEN_TIME  = 35,
  parameter int YELLOW_TIME = 5,
  parameter int RED_TIME    = 30,
  parameter int PED_GREEN   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ped_req,
  input  logic       force_red,
  output logic [2:0] sel,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       tick,
  output logic       phase_start
);

  localparam int              PW         = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX    = PW'(CLK_DIV - 1);
  localparam logic [7:0]      BCD_GREEN  = to_bcd(GREEN_TIME);
  localparam logic [7:0]      BCD_YELLOW = to_bcd(YELLOW_TIME);
  localparam logic [7:0]      BCD_RED    = to_bcd(RED_TIME);
  localparam logic [7:0]      BCD_PED    = to_bcd(PED_GREEN);

  if (CLK_DIV < 2 ||
      GREEN_TIME < 1 || GREEN_TIME > 99 ||
      YELLOW_TIME < 1 || YELLOW_TIME > 99 ||
      RED_TIME < 1 || RED_TIME > 99 ||
      PED_GREEN < 0 || PED_GREEN >= GREEN_TIME) begin : g_bad_params
    $error("traffic_phase_timer: illegal parameter set");
  end

  logic [PW-1:0] pre_q;
  phase_t        state_q, state_d;
  logic [2:0]    sel_q;
  logic          ps_q, ps_d;
  logic          ped_q;
  logic          load, dec, cnt_zero, green_exit;
  logic [7:0]    load_val;

  assign tick = en && (pre_q == PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (en) begin
      pre_q <= (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
    end
  end

  // Force-red acts on any clock in GREEN; everything else waits for a tick.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    load_val   = 8'h00;
    dec        = 1'b0;
    ps_d       = 1'b0;
    green_exit = 1'b0;
    case (state_q)
      GREEN: begin
        if (force_red || (tick && cnt_zero)) begin
          state_d    = YELLOW;
          load       = 1'b1;
          load_val   = BCD_YELLOW;
          ps_d       = 1'b1;
          green_exit = 1'b1;
        end else if (tick) begin
          if (ped_q && ({tens, ones} > BCD_PED)) begin
            load     = 1'b1;
            load_val = BCD_PED;
          end else begin
            dec = 1'b1;
          end
        end
      end
      YELLOW: begin
        if (tick) begin
          if (cnt_zero) begin
            state_d  = RED;
            load     = 1'b1;
            load_val = BCD_RED;
            ps_d     = 1'b1;
          end else begin
            dec = 1'b1;
          end
        end
      end
      RED: begin
        if (tick && !force_red) begin
          if (cnt_zero) begin
            state_d  = GREEN;
            load     = 1'b1;
            load_val = BCD_GREEN;
            ps_d     = 1'b1;
          end else begin
            dec = 1'b1;
          end
        end
      end
      default: begin
        state_d = RED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RED;
      sel_q   <= LIGHT_RED;
      ps_q    <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= light_sel(state_d);
      ps_q    <= ps_d;
      ped_q   <= (ped_q | ped_req) & ~green_exit;
    end
  end

  bcd_down_counter #(
    .RESET_VAL (BCD_RED)
  ) u_count (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .tens     (tens),
    .ones     (ones),
    .zero     (cnt_zero)
  );

  assign sel         = sel_q;
  assign phase_start = ps_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb/tb_traffic_phase_timer.sv - directed scoreboard bench for traffic_phase_timer
module tb_traffic_phase_timer;

  localparam int G_T = 35;
  localparam int Y_T = 5;
  localparam int R_T = 30;

  logic       clk = 1'b0;
  logic       rst_n, en, ped_req, force_red;
  logic [2:0] sel;
  logic [3:0] tens, ones;
  logic       tick, phase_start;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c1;

  int         m_val;
  logic [2:0] m_sel;

  typedef struct {
    string      tag;
    logic [2:0] sel;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ps;
  } exp_t;

  exp_t sb[$];

  traffic_phase_timer #(
    .CLK_DIV     (4),
    .GREEN_TIME  (G_T),
    .YELLOW_TIME (Y_T),
    .RED_TIME    (R_T),
    .PED_GREEN   (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ped_req     (ped_req),
    .force_red   (force_red),
    .sel         (sel),
    .tens        (tens),
    .ones        (ones),
    .tick        (tick),
    .phase_start (phase_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_now(input string tag, input logic [2:0] s, input int v, input logic ps);
    chk({tag, "_sel"}, int'(sel), int'(s));
    chk({tag, "_tens"}, int'(tens), v / 10);
    chk({tag, "_ones"}, int'(ones), v % 10);
    chk({tag, "_phase_start"}, int'(phase_start), int'(ps));
  endtask

  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_tick_seen"}, int'(seen), 1);
  endtask

  task automatic tick_expect(input string tag, input logic [2:0] s, input int v);
    exp_t e;
    e.tag  = tag;
    e.sel  = s;
    e.tens = 4'(v / 10);
    e.ones = 4'(v % 10);
    e.ps   = (s != m_sel);
    m_sel  = s;
    m_val  = v;
    sb.push_back(e);
    wait_tick(tag);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, "_sel"}, int'(sel), int'(e.sel));
    chk({e.tag, "_tens"}, int'(tens), int'(e.tens));
    chk({e.tag, "_ones"}, int'(ones), int'(e.ones));
    chk({e.tag, "_phase_start"}, int'(phase_start), int'(e.ps));
  endtask

  task automatic tick_model(input string tag);
    logic [2:0] ns;
    int         nv;
    ns = m_sel;
    nv = m_val - 1;
    if (m_val == 0) begin
      case (m_sel)
        3'b100:  begin ns = 3'b001; nv = G_T; end
        3'b001:  begin ns = 3'b010; nv = Y_T; end
        default: begin ns = 3'b100; nv = R_T; end
      endcase
    end
    tick_expect(tag, ns, nv);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; ped_req = 1'b0; force_red = 1'b0;
    repeat (2) @(negedge clk);
    chk_now("reset", 3'b100, 30, 1'b0);
    chk("reset_tick", int'(tick), 0);
    rst_n = 1'b1;
    m_sel = 3'b100; m_val = R_T;

    for (int i = 0; i < 31; i++) tick_model("red_walk");
    c1 = cyc;
    for (int i = 0; i < 73; i++) tick_model("cycle");
    chk("cycle_clocks", cyc - c1, 292);

    for (int i = 0; i < 15; i++) tick_model("green_walk");
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    tick_expect("ped_jump", 3'b001, 5);
    for (int i = 0; i < 6; i++) tick_model("ped_tail");
    for (int i = 0; i < 37; i++) tick_model("to_green");
    tick_model("latch_cleared");

    for (int i = 0; i < 31; i++) tick_model("green_low");
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    tick_model("ped_no_effect");
    for (int i = 0; i < 3; i++) tick_model("green_end");
    for (int i = 0; i < 37; i++) tick_model("to_green2");
    for (int i = 0; i < 3; i++) tick_model("green_mid");

    force_red = 1'b1;
    @(negedge clk);
    chk_now("force_yellow", 3'b010, 5, 1'b1);
    m_sel = 3'b010; m_val = Y_T;
    for (int i = 0; i < 6; i++) tick_model("force_yel");
    repeat (2) tick_expect("red_frozen", 3'b100, 30);
    force_red = 1'b0;
    tick_model("red_resume");

    for (int i = 0; i < 12; i++) tick_model("red_walk2");
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("en_off_tick", int'(tick), 0);
      chk_now("en_off_hold", 3'b100, 17, 1'b0);
    end
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_back_tick", int'(tick), 1);
    chk_now("en_back_hold", 3'b100, 17, 1'b0);
    @(negedge clk);
    chk_now("en_resume", 3'b100, 16, 1'b0);
    m_val = 16;

    for (int i = 0; i < 17; i++) tick_model("red_finish");
    en = 1'b0;
    force_red = 1'b1;
    @(negedge clk);
    chk_now("force_no_tick", 3'b010, 5, 1'b1);
    force_red = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_now("async_reset", 3'b100, 30, 1'b0);
    chk("async_reset_tick", int'(tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    m_sel = 3'b100; m_val = R_T;
    tick_model("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_timer.md
Name: traffic_phase_timer

Overview:
- Sequential countdown controller for the traffic-light path: prescaler tick, GREEN→YELLOW→RED phase FSM and a two-digit BCD countdown per phase.
- Drives the existing seven-segment decoder directly with a one-hot light select plus tens/ones BCD digits.
- Generalises the fixed 35/5/30 s sequence with parametrised durations and prescale.
- Adds pause, pedestrian-shortened green and emergency force-red.

Parameters:
- CLK_DIV, 100000000, clock cycles per countdown tick (≥2).
- GREEN_TIME, 35, green duration in ticks (1..99).
- YELLOW_TIME, 5, yellow duration in ticks (1..99).
- RED_TIME, 30, red duration in ticks (1..99).
- PED_GREEN, 5, remaining-green value forced on pedestrian request (< GREEN_TIME).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; 0 freezes prescaler and countdown.
- ped_req  in  1  pedestrian request; single-cycle pulse or level.
- force_red  in  1  emergency level request.
- sel  out  3  one-hot light: 001 green, 010 yellow, 100 red.
- tens  out  4  BCD tens digit of remaining count.
- ones  out  4  BCD ones digit of remaining count.
- tick  out  1  one-cycle prescaler pulse.
- phase_start  out  1  one-cycle pulse on the clock a new phase loads.

Behaviour:
- Clocking and reset: one clock. rst_n is asynchronous and active-low; all flops clear on its falling edge regardless of clk.
- Reset values:
  - state = RED, sel = 100.
  - tens/ones = BCD(RED_TIME); defaults give 3/0.
  - Prescaler = 0, tick = 0, phase_start = 0, ped latch = 0.
- Prescaler: counts 0..CLK_DIV-1 while en=1. tick=1 for the cycle the count equals CLK_DIV-1, then it wraps to 0. en=0 holds the count and tick=0.
- Countdown, on each tick:
  - If {tens,ones} != 00: BCD decrement. ones>0 → ones-1; else ones=9 and tens-1.
  - If {tens,ones} == 00: advance phase and load the new duration in the same cycle; phase_start=1.
  - A phase of duration D therefore displays D, D-1, …, 0, i.e. D+1 ticks.
- FSM transitions: GREEN→YELLOW→RED→GREEN. sel is registered and changes in the same cycle as the count reload.
- Pedestrian request:
  - ped_req=1 on any clock sets ped latch.
  - On a tick in GREEN with latch=1 and count > PED_GREEN: count loads BCD(PED_GREEN) instead of decrementing.
  - Latch clears when GREEN exits.
  - A request made during YELLOW/RED shortens the next GREEN.
  - A request when count ≤ PED_GREEN has no effect on the count.
- Force red:
  - force_red=1 in GREEN: next clock (not tick) enters YELLOW with YELLOW_TIME; phase_start=1.
  - In YELLOW: countdown continues normally.
  - In RED: countdown frozen at its current value, no phase advance; resumes on deassert.
  - Priority force_red > ped_req > normal decrement.
- Simultaneous events:
  - en=0 masks ticks only; force_red still acts in GREEN.
  - Reset mid-phase returns to the reset values immediately.
- Digits always hold legal BCD (0–9). Durations outside 1..99 are an elaboration error.

Decomposition:
- Shared package traffic_pkg:
  - Light encodings LIGHT_GREEN=3'b001, LIGHT_YELLOW=3'b010, LIGHT_RED=3'b100.
  - Phase state enum {RED, GREEN, YELLOW}.
  - Function to_bcd(int) returning {tens,ones}.
- One sub-module: bcd_down_counter (load, load_val[7:0], dec, tens, ones, zero flag).
- Prescaler and FSM stay inline.

Test Plan:
- Run with CLK_DIV=4 and defaults:
  - After reset, observe sel=100, 3/0.
  - RED counts down 30..0 over 31 ticks, then sel=001 at 3/5.
  - Full cycle takes (31+36+6)×4 = 292 clocks.
- GREEN at 2/0: pulse ped_req → next tick shows 0/5, then 4..0 → YELLOW 0/5; latch cleared.
- GREEN at 0/3 with ped_req → no jump, normal decrement to 0/2.
- Assert force_red mid-GREEN → YELLOW 0/5 on next clock.
  - YELLOW reaches 0 → RED 3/0.
  - While held, RED stays at its current count.
  - Deassert → countdown resumes.
- Hold en=0 for 20 clocks mid-RED at 1/7 → digits and prescaler frozen, tick=0; resumes at 1/6 after 4 clocks.
- Assert rst_n=0 asynchronously mid-YELLOW (between clk edges) → immediate sel=100, 3/0, phase_start=0.
